uart_host_bridge: RTL and testbench

UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

---
 rtl/uart_host_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_host_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_bridge.sv
// Host command bridge to an 8-bit async-strobe UART peripheral, with autonomous RX interrupt service.
// Write completes at T+4, read at T+3; CMD_READY is low while busy or while an interrupt is pending.
module uart_host_bridge #(
  parameter int RXBIT = 1
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WRITE,
  input  logic [1:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  input  logic       IRQ_EN,
  output logic       RXB_VALID,
  output logic [7:0] RXB_DATA,
  output logic [7:0] STAT_LAST,
  output logic [1:0] ADDR,
  output logic       NCS,
  output logic       NO,
  output logic       NW,
  inout  wire  [7:0] DATA,
  input  logic       NINT
);

  localparam logic [2:0] RXIDX = 3'(RXBIT);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_SAMPLE, GAP
  } state_e;

  // Who owns the current bus transaction: the host, or one of the two service reads.
  typedef enum logic [1:0] {K_CMD, K_STAT, K_RXD} kind_e;

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ncs_q, ncs_d;
  logic       no_q, no_d;
  logic       nw_q, nw_d;
  logic       drv_q, drv_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rxb_valid_q, rxb_valid_d;
  logic [7:0] rxb_data_q, rxb_data_d;
  logic [7:0] stat_last_q, stat_last_d;
  logic       svc_req;

  assign svc_req   = IRQ_EN & ~NINT;
  assign CMD_READY = NRST & (state_q == IDLE) & ~svc_req;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q     <= IDLE;
      kind_q      <= K_CMD;
      addr_q      <= 2'd0;
      wdata_q     <= 8'h00;
      ncs_q       <= 1'b1;
      no_q        <= 1'b1;
      nw_q        <= 1'b1;
      drv_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rxb_valid_q <= 1'b0;
      rxb_data_q  <= 8'h00;
      stat_last_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ncs_q       <= ncs_d;
      no_q        <= no_d;
      nw_q        <= nw_d;
      drv_q       <= drv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rxb_valid_q <= rxb_valid_d;
      rxb_data_q  <= rxb_data_d;
      stat_last_q <= stat_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // A pending interrupt outranks any host command.
        if (svc_req) begin
          state_d = R_SETUP;
          kind_d  = K_STAT;
          addr_d  = 2'd0;
        end else if (CMD_VALID) begin
          state_d = CMD_WRITE ? W_SETUP : R_SETUP;
          kind_d  = K_CMD;
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
        end
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD:   state_d = GAP;
      R_SETUP:  state_d = R_SAMPLE;
      R_SAMPLE: state_d = GAP;
      GAP: begin
        // stat_last_q already holds the status byte captured at the end of R_SAMPLE.
        if (kind_q == K_STAT && stat_last_q[RXIDX]) begin
          state_d = R_SETUP;
          kind_d  = K_RXD;
          addr_d  = 2'd2;
        end else begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ncs_d       = (state_d == IDLE) || (state_d == GAP);
    no_d        = !((state_d == R_SETUP) || (state_d == R_SAMPLE));
    nw_d        = (state_d != W_STROBE);
    drv_d       = (state_d == W_SETUP) || (state_d == W_STROBE) || (state_d == W_HOLD);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rxb_valid_d = 1'b0;
    rxb_data_d  = rxb_data_q;
    stat_last_d = stat_last_q;
    if (state_q == W_HOLD) begin
      rsp_valid_d = 1'b1;
    end else if (state_q == R_SAMPLE) begin
      unique case (kind_q)
        K_CMD: begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = DATA;
        end
        K_STAT: stat_last_d = DATA;
        K_RXD: begin
          rxb_valid_d = 1'b1;
          rxb_data_d  = DATA;
        end
        default: ;
      endcase
    end
  end

  assign DATA      = drv_q ? wdata_q : 8'hzz;
  assign ADDR      = addr_q;
  assign NCS       = ncs_q;
  assign NO        = no_q;
  assign NW        = nw_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RXB_VALID = rxb_valid_q;
  assign RXB_DATA  = rxb_data_q;
  assign STAT_LAST = stat_last_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge with a simple register-file peripheral on the strobe bus.
module tb_uart_host_bridge;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_WRITE;
  logic [1:0] CMD_ADDR;
  logic [7:0] CMD_WDATA;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       IRQ_EN;
  logic       RXB_VALID;
  logic [7:0] RXB_DATA;
  logic [7:0] STAT_LAST;
  logic [1:0] ADDR;
  logic       NCS;
  logic       NO;
  logic       NW;
  wire  [7:0] DATA;
  logic       NINT;

  int nvec = 0;
  int nerr = 0;

  // Peripheral: read values set by the bench, writes logged on each strobe edge.
  logic [7:0] periph_rd [4];
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'h00;
  int         wr_cnt  = 0;

  assign DATA = (!NCS && !NO) ? periph_rd[ADDR] : 8'hzz;

  always @(posedge CLK) begin
    if (NRST && !NCS && !NW) begin
      wr_addr <= ADDR;
      wr_data <= DATA;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  always #5 CLK = ~CLK;

  uart_host_bridge #(.RXBIT(1)) dut (
    .CLK(CLK), .NRST(NRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .IRQ_EN(IRQ_EN), .RXB_VALID(RXB_VALID), .RXB_DATA(RXB_DATA), .STAT_LAST(STAT_LAST),
    .ADDR(ADDR), .NCS(NCS), .NO(NO), .NW(NW), .DATA(DATA), .NINT(NINT)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check_eq({tag, " NCS"}, {7'd0, NCS}, 8'd1);
    check_eq({tag, " NO"},  {7'd0, NO},  8'd1);
    check_eq({tag, " NW"},  {7'd0, NW},  8'd1);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic [7:0] rdata_hold);
    int cnt0;
    cnt0 = wr_cnt;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = a; CMD_WDATA = d;
    check_eq("wr ready", {7'd0, CMD_READY}, 8'd1);
    tick();
    CMD_VALID = 1'b0; CMD_ADDR = ~a; CMD_WDATA = ~d;
    check_eq("wr setup NCS", {7'd0, NCS}, 8'd0);
    check_eq("wr setup NW", {7'd0, NW}, 8'd1);
    check_eq("wr setup NO", {7'd0, NO}, 8'd1);
    check_eq("wr setup ADDR", {6'd0, ADDR}, {6'd0, a});
    check_eq("wr setup DATA", DATA, d);
    check_eq("wr busy ready", {7'd0, CMD_READY}, 8'd0);
    tick();
    check_eq("wr strobe NCS", {7'd0, NCS}, 8'd0);
    check_eq("wr strobe NW", {7'd0, NW}, 8'd0);
    check_eq("wr strobe NO", {7'd0, NO}, 8'd1);
    check_eq("wr strobe DATA", DATA, d);
    check_eq("wr strobe ADDR", {6'd0, ADDR}, {6'd0, a});
    tick();
    check_eq("wr hold NCS", {7'd0, NCS}, 8'd0);
    check_eq("wr hold NW", {7'd0, NW}, 8'd1);
    check_eq("wr hold DATA", DATA, d);
    check_eq("wr hold rsp", {7'd0, RSP_VALID}, 8'd0);
    tick();
    check_idle_bus("wr gap");
    check_eq("wr gap rsp", {7'd0, RSP_VALID}, 8'd1);
    check_eq("wr periph addr", {6'd0, wr_addr}, {6'd0, a});
    check_eq("wr periph data", wr_data, d);
    check_eq("wr strobe count", 8'(wr_cnt - cnt0), 8'd1);
    check_eq("wr rdata kept", RSP_RDATA, rdata_hold);
    tick();
    check_eq("wr after rsp", {7'd0, RSP_VALID}, 8'd0);
    check_eq("wr after ready", {7'd0, CMD_READY}, 8'd1);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [7:0] exp);
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = a; CMD_WDATA = 8'h00;
    tick();
    CMD_VALID = 1'b0; CMD_ADDR = ~a;
    check_eq("rd setup NCS", {7'd0, NCS}, 8'd0);
    check_eq("rd setup NO", {7'd0, NO}, 8'd0);
    check_eq("rd setup NW", {7'd0, NW}, 8'd1);
    check_eq("rd setup ADDR", {6'd0, ADDR}, {6'd0, a});
    tick();
    check_eq("rd sample NCS", {7'd0, NCS}, 8'd0);
    check_eq("rd sample NO", {7'd0, NO}, 8'd0);
    check_eq("rd sample ADDR", {6'd0, ADDR}, {6'd0, a});
    check_eq("rd sample rsp", {7'd0, RSP_VALID}, 8'd0);
    tick();
    check_idle_bus("rd gap");
    check_eq("rd gap rsp", {7'd0, RSP_VALID}, 8'd1);
    check_eq("rd gap rdata", RSP_RDATA, exp);
    check_eq("rd gap rxb", {7'd0, RXB_VALID}, 8'd0);
    tick();
    check_eq("rd after rsp", {7'd0, RSP_VALID}, 8'd0);
    check_eq("rd rdata held", RSP_RDATA, exp);
  endtask

  initial begin
    NRST = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 2'd0; CMD_WDATA = 8'h00;
    IRQ_EN = 1'b0; NINT = 1'b1;
    periph_rd[0] = 8'h00; periph_rd[1] = 8'h5C; periph_rd[2] = 8'h41; periph_rd[3] = 8'h00;
    tick();
    tick();
    check_idle_bus("rst");
    check_eq("rst ADDR", {6'd0, ADDR}, 8'd0);
    check_eq("rst rsp", {7'd0, RSP_VALID}, 8'd0);
    check_eq("rst rxb", {7'd0, RXB_VALID}, 8'd0);
    check_eq("rst rdata", RSP_RDATA, 8'h00);
    check_eq("rst rxbdata", RXB_DATA, 8'h00);
    check_eq("rst stat", STAT_LAST, 8'h00);
    check_eq("rst ready", {7'd0, CMD_READY}, 8'd0);
    NRST = 1'b1;
    #1;
    check_eq("post rst ready", {7'd0, CMD_READY}, 8'd1);

    do_write(2'd3, 8'h1A, 8'h00);
    do_read(2'd1, 8'h5C);
    do_write(2'd1, 8'hA5, 8'h5C);

    // Interrupt with RX flag set, plus a competing host read of addr 1.
    periph_rd[0] = 8'h02; periph_rd[1] = 8'h77; periph_rd[2] = 8'h41;
    IRQ_EN = 1'b1; NINT = 1'b0;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 2'd1;
    #1;
    check_eq("svc ready blocked", {7'd0, CMD_READY}, 8'd0);
    tick();
    NINT = 1'b1;
    check_eq("svc st NO", {7'd0, NO}, 8'd0);
    check_eq("svc st ADDR", {6'd0, ADDR}, 8'd0);
    tick();
    check_eq("svc st sample NCS", {7'd0, NCS}, 8'd0);
    tick();
    check_idle_bus("svc gap1");
    check_eq("svc stat", STAT_LAST, 8'h02);
    check_eq("svc gap1 rsp", {7'd0, RSP_VALID}, 8'd0);
    check_eq("svc gap1 ready", {7'd0, CMD_READY}, 8'd0);
    tick();
    check_eq("svc dt NO", {7'd0, NO}, 8'd0);
    check_eq("svc dt ADDR", {6'd0, ADDR}, 8'd2);
    tick();
    check_eq("svc dt sample NCS", {7'd0, NCS}, 8'd0);
    tick();
    check_idle_bus("svc gap2");
    check_eq("svc rxb valid", {7'd0, RXB_VALID}, 8'd1);
    check_eq("svc rxb data", RXB_DATA, 8'h41);
    check_eq("svc gap2 rsp", {7'd0, RSP_VALID}, 8'd0);
    check_eq("svc rdata kept", RSP_RDATA, 8'h5C);
    tick();
    check_eq("svc done rxb", {7'd0, RXB_VALID}, 8'd0);
    check_eq("svc done ready", {7'd0, CMD_READY}, 8'd1);
    do_read(2'd1, 8'h77);

    // Status without the RX flag: a single status read, then idle.
    periph_rd[0] = 8'h00;
    NINT = 1'b0;
    tick();
    NINT = 1'b1;
    check_eq("svc0 ADDR", {6'd0, ADDR}, 8'd0);
    check_eq("svc0 NO", {7'd0, NO}, 8'd0);
    tick();
    tick();
    check_eq("svc0 stat", STAT_LAST, 8'h00);
    check_eq("svc0 rxb", {7'd0, RXB_VALID}, 8'd0);
    tick();
    check_idle_bus("svc0 idle");
    check_eq("svc0 idle ready", {7'd0, CMD_READY}, 8'd1);
    check_eq("svc0 rxbdata kept", RXB_DATA, 8'h41);
    tick();
    check_idle_bus("svc0 still idle");
    check_eq("svc0 no rxb", {7'd0, RXB_VALID}, 8'd0);

    // NINT held low: service repeats after one idle cycle.
    NINT = 1'b0;
    tick();
    tick();
    tick();
    check_idle_bus("rep gap");
    tick();
    check_idle_bus("rep idle");
    check_eq("rep idle ready", {7'd0, CMD_READY}, 8'd0);
    tick();
    NINT = 1'b1;
    check_eq("rep restart NCS", {7'd0, NCS}, 8'd0);
    check_eq("rep restart ADDR", {6'd0, ADDR}, 8'd0);
    tick();
    tick();
    tick();
    check_idle_bus("rep end");
    check_eq("rep end ready", {7'd0, CMD_READY}, 8'd1);
    IRQ_EN = 1'b0;

    // Reset during the write strobe.
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 2'd2; CMD_WDATA = 8'h99;
    tick();
    CMD_VALID = 1'b0;
    tick();
    check_eq("rstw strobe NW", {7'd0, NW}, 8'd0);
    NRST = 1'b0;
    #1;
    check_eq("rstw ready", {7'd0, CMD_READY}, 8'd0);
    tick();
    check_idle_bus("rstw");
    check_eq("rstw ADDR", {6'd0, ADDR}, 8'd0);
    check_eq("rstw rsp", {7'd0, RSP_VALID}, 8'd0);
    check_eq("rstw rdata", RSP_RDATA, 8'h00);
    check_eq("rstw rxbdata", RXB_DATA, 8'h00);
    check_eq("rstw stat", STAT_LAST, 8'h00);
    NRST = 1'b1;
    tick();
    check_eq("rstw after rsp", {7'd0, RSP_VALID}, 8'd0);
    check_idle_bus("rstw after");
    check_eq("rstw after ready", {7'd0, CMD_READY}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
